// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Word-to-serial controller with a programmable pattern matcher. Parallel words are
// accepted over valid/ready, shifted out MSB-first on a/a_vld, and the resulting bit
// stream is compared against a 1..PAT_MAX bit pattern. Each match produces a one-cycle
// op pulse and bumps a saturating counter. The bit history carries over between words,
// so a pattern that spans a word boundary is still detected.
module seq_detect_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(PAT_MAX) + 1,
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               a,
  output logic               a_vld,
  output logic               op,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  localparam logic [1:0] UNCFG = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]         state_r;
  logic [DATA_W-1:0]  word_r;
  logic [IDX_W-1:0]   idx_r;
  logic [PAT_MAX-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [PAT_MAX-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic               op_r;
  logic               cfg_err_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               bit_s;
  logic [PAT_MAX-1:0] hist_next_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [PAT_MAX-1:0] mask_s;
  logic               hit_s;
  logic               cfg_ok_s;

  // Next history/fill values and match decision for the current shift edge.
  always_comb begin
    bit_s       = word_r[idx_r];
    hist_next_s = {hist_r[PAT_MAX-2:0], bit_s};
    if (fill_r == LEN_W'(PAT_MAX)) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + LEN_W'(1);
    end
    mask_s = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    hit_s    = (state_r == SHIFT) && (fill_next_s >= len_r) &&
               ((hist_next_s & mask_s) == (pat_r & mask_s));
    cfg_ok_s = (cfg_len != LEN_W'(0)) && (cfg_len <= LEN_W'(PAT_MAX));
  end

  // Controller state, configuration, serializer and match bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= UNCFG;
      word_r    <= '0;
      idx_r     <= '0;
      hist_r    <= '0;
      fill_r    <= '0;
      pat_r     <= '0;
      len_r     <= '0;
      overlap_r <= 1'b0;
      op_r      <= 1'b0;
      cfg_err_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      op_r      <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        UNCFG, IDLE: begin
          if (cfg_we) begin
            // Config has priority over a word offered in the same cycle.
            if (cfg_ok_s) begin
              pat_r     <= cfg_pattern;
              len_r     <= cfg_len;
              overlap_r <= cfg_overlap;
              hist_r    <= '0;
              fill_r    <= '0;
              cnt_r     <= '0;
              state_r   <= IDLE;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end else if ((state_r == IDLE) && in_valid) begin
            word_r  <= in_data;
            idx_r   <= IDX_W'(DATA_W - 1);
            state_r <= SHIFT;
          end else begin
            state_r <= state_r;
          end
        end
        SHIFT: begin
          if (cfg_we) begin
            cfg_err_r <= 1'b1;
          end else begin
            cfg_err_r <= 1'b0;
          end
          hist_r <= hist_next_s;
          if (hit_s) begin
            op_r <= 1'b1;
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
            // Without overlap the next match must be built from fresh bits.
            fill_r <= overlap_r ? fill_next_s : LEN_W'(0);
          end else begin
            fill_r <= fill_next_s;
          end
          if (idx_r == IDX_W'(0)) begin
            state_r <= IDLE;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        default: begin
          state_r <= UNCFG;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == SHIFT);
  assign a_vld     = (state_r == SHIFT);
  assign a         = (state_r == SHIFT) & word_r[idx_r];
  assign op        = op_r;
  assign cfg_err   = cfg_err_r;
  assign match_cnt = cnt_r;

endmodule
